// File: rtl/vedic_mac_accumulator_pkg.sv
// Shared definitions for the Vedic multiply-accumulate frame engine:
// FSM state encodings and default datapath widths.
package vedic_mac_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int ACC_W_DEF = 16;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/vedicMulti4x4.sv
// 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier built from four 2x2
// vertical-and-crosswise partial products; purely combinational.
module vedicMulti4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] y
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] z);
    logic t1, t2, c1, t3;
    logic [3:0] p;
    p[0] = x[0] & z[0];
    t1   = x[1] & z[0];
    t2   = x[0] & z[1];
    p[1] = t1 ^ t2;
    c1   = t1 & t2;
    t3   = x[1] & z[1];
    p[2] = t3 ^ c1;
    p[3] = t3 & c1;
    return p;
  endfunction

  logic [3:0] q0, q1, q2, q3;

  assign q0 = mul2(a[1:0], b[1:0]);
  assign q1 = mul2(a[3:2], b[1:0]);
  assign q2 = mul2(a[1:0], b[3:2]);
  assign q3 = mul2(a[3:2], b[3:2]);

  // Cross terms carry weight 4, the high term weight 16.
  assign y = {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};

endmodule

// File: rtl/vedic_mac_accumulator.sv
// Frame-based multiply-accumulate: multiplies 4-bit operand pairs with a Vedic
// multiplier and sums products until in_last, then offers sum/count/overflow.
module vedic_mac_accumulator
  import vedic_mac_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state, state_nxt;
  logic             accept;
  logic [3:0]       a_p1, b_p1;
  logic             vld_p1;
  logic [7:0]       prod_p1;
  logic [ACC_W:0]   sum_ext_p1;
  logic [ACC_W-1:0] acc_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic             ovf_p2;

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (accept && in_last) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_ACC;
      default:  state_nxt = ST_ACC;
    endcase
  end

  // Stage 1: capture accepted operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1 <= in_a;
      b_p1 <= in_b;
    end
  end

  vedicMulti4x4 u_mult (
    .a (a_p1),
    .b (b_p1),
    .y (prod_p1)
  );

  assign sum_ext_p1 = {1'b0, acc_p2} + {{(ACC_W - 7){1'b0}}, prod_p1};

  // Stage 2: accumulate; the handoff edge clears state for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
      cnt_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (out_valid && out_ready) begin
      acc_p2 <= '0;
      cnt_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (vld_p1) begin
      acc_p2 <= sum_ext_p1[ACC_W-1:0];
      cnt_p2 <= sat_inc(cnt_p2);
      ovf_p2 <= ovf_p2 | sum_ext_p1[ACC_W];
    end
  end

  assign out_sum   = acc_p2;
  assign out_count = cnt_p2;
  assign out_ovf   = ovf_p2;

endmodule

// File: tb/tb_vedic_mac_accumulator.sv
// Directed bench for vedic_mac_accumulator: a 16-bit and an 8-bit accumulator
// instance share one input stream; each frame result is checked on both.
module tb_vedic_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_w16, out_valid_w16, out_ovf_w16;
  logic [15:0] out_sum_w16;
  logic [7:0]  out_count_w16;
  logic        in_ready_w8, out_valid_w8, out_ovf_w8;
  logic [7:0]  out_sum_w8;
  logic [7:0]  out_count_w8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vedic_mac_accumulator #(.ACC_W(16), .CNT_W(8)) dut_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_w16), .out_ready(out_ready),
    .out_sum(out_sum_w16), .out_count(out_count_w16), .out_ovf(out_ovf_w16)
  );

  vedic_mac_accumulator #(.ACC_W(8), .CNT_W(8)) dut_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w8),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid_w8), .out_ready(out_ready),
    .out_sum(out_sum_w8), .out_count(out_count_w8), .out_ovf(out_ovf_w8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present a beat and hold it until an edge on which in_ready was high.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
    int   guard;
    logic took;
    guard = 0;
    took  = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!took && guard < 50) begin
      took = in_ready_w16;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!took) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Called #1 after the edge that accepted the last beat.
  task automatic finish_frame(input string tag,
                              input logic [31:0] sum16, input logic [31:0] sum8,
                              input logic [31:0] cnt,
                              input logic ovf16, input logic ovf8);
    check({tag, "_flush_valid"}, 32'(out_valid_w16), 32'd0);
    check({tag, "_flush_ready"}, 32'(in_ready_w16), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid16"}, 32'(out_valid_w16), 32'd1);
    check({tag, "_valid8"},  32'(out_valid_w8), 32'd1);
    check({tag, "_sum16"},   32'(out_sum_w16), sum16);
    check({tag, "_sum8"},    32'(out_sum_w8), sum8);
    check({tag, "_count16"}, 32'(out_count_w16), cnt);
    check({tag, "_count8"},  32'(out_count_w8), cnt);
    check({tag, "_ovf16"},   32'(out_ovf_w16), 32'(ovf16));
    check({tag, "_ovf8"},    32'(out_ovf_w8), 32'(ovf8));
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ho_valid"}, 32'(out_valid_w16), 32'd0);
    check({tag, "_ho_ready"}, 32'(in_ready_w16), 32'd1);
    check({tag, "_ho_sum"},   32'(out_sum_w16), 32'd0);
    check({tag, "_ho_count"}, 32'(out_count_w16), 32'd0);
    check({tag, "_ho_ovf8"},  32'(out_ovf_w8), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid_w16), 32'd0);
    check("rst_ready", 32'(in_ready_w16), 32'd1);
    check("rst_sum",   32'(out_sum_w16), 32'd0);
    check("rst_count", 32'(out_count_w16), 32'd0);
    check("rst_ovf",   32'(out_ovf_w16), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", 32'(out_valid_w16), 32'd0);
    // out_ready outside DONE must be ignored
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready_ignored", 32'(in_ready_w16), 32'd1);

    // 1: single beat 10*10
    send(4'd10, 4'd10, 1'b1);
    finish_frame("t1", 32'd100, 32'd100, 32'd1, 1'b0, 1'b0);
    handoff("t1");

    // 2: 12+120+15+225 = 372 ; 8-bit: 116 with wrap
    send(4'd2, 4'd6, 1'b0);
    send(4'd10, 4'd12, 1'b0);
    send(4'd3, 4'd5, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    finish_frame("t2", 32'd372, 32'd116, 32'd4, 1'b0, 1'b1);

    // 3: back-pressure with a beat offered while blocked
    in_valid = 1'b1;
    in_a = 4'd1;
    in_b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(out_valid_w16), 32'd1);
      check("t3_hold_sum",   32'(out_sum_w16), 32'd372);
      check("t3_hold_ready", 32'(in_ready_w16), 32'd0);
    end
    in_valid = 1'b0;
    check("t3_hold_count", 32'(out_count_w16), 32'd4);
    handoff("t3");
    send(4'd8, 4'd7, 1'b1);
    finish_frame("t3b", 32'd56, 32'd56, 32'd1, 1'b0, 1'b0);
    handoff("t3b");

    // 4: 225+225 = 450 ; 8-bit wraps to 194
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    finish_frame("t4", 32'd450, 32'd194, 32'd2, 1'b0, 1'b1);
    handoff("t4");
    send(4'd1, 4'd1, 1'b1);
    finish_frame("t4b", 32'd1, 32'd1, 32'd1, 1'b0, 1'b0);
    handoff("t4b");

    // 5: reset mid-frame discards the partial sum
    send(4'd10, 4'd10, 1'b0);
    send(4'd2, 4'd6, 1'b0);
    check("t5_partial_sum", 32'(out_sum_w16), 32'd100);
    rst_n = 1'b0;
    #2;
    check("t5_rst_valid", 32'(out_valid_w16), 32'd0);
    check("t5_rst_sum",   32'(out_sum_w16), 32'd0);
    check("t5_rst_count", 32'(out_count_w16), 32'd0);
    check("t5_rst_ovf",   32'(out_ovf_w16), 32'd0);
    check("t5_rst_ready", 32'(in_ready_w16), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_post_valid", 32'(out_valid_w16), 32'd0);
    check("t5_post_sum",   32'(out_sum_w16), 32'd0);
    send(4'd3, 4'd5, 1'b1);
    finish_frame("t5", 32'd15, 32'd15, 32'd1, 1'b0, 1'b0);
    handoff("t5");

    // 6: gaps inside a frame, 120+56 = 176
    send(4'd10, 4'd12, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_gap_valid", 32'(out_valid_w16), 32'd0);
    send(4'd8, 4'd7, 1'b1);
    finish_frame("t6", 32'd176, 32'd176, 32'd2, 1'b0, 1'b0);
    handoff("t6");

    // 6b: 300 beats of 1*1 ; count saturates at 255, 8-bit sum wraps to 44
    for (int i = 0; i < 299; i++) send(4'd1, 4'd1, 1'b0);
    send(4'd1, 4'd1, 1'b1);
    finish_frame("t6b", 32'd300, 32'd44, 32'd255, 1'b0, 1'b1);
    handoff("t6b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
